regbank: RTL and testbench

Parametrised register bank for the nic8 datapath: NREGS general registers of WIDTH bits, loaded from the data bus, with two combinational read ports. An output queue of OUT_DEPTH entries replaces the single output register, so `doOut` pushes a bus value and an external consumer drains it over a valid/ready handshake. The bank sits beside the control decoder and takes its load, push and select signals from the decoded control word.

---
 rtl/nic8_pkg.sv | 32 +++
 rtl/regbank_out_fifo.sv | 63 ++++++
 rtl/regbank.sv | 52 +++++
 tb/tb_regbank.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/nic8_pkg.sv
// Shared nic8 constants: default datapath width and control-word field layout,
// so the decoder and the register bank agree on where load/push/select bits live.
package nic8_pkg;

  localparam int NIC8_WIDTH = 8;

  localparam int CW_LOAD_BIT  = 0;
  localparam int CW_PUSH_BIT  = 1;
  localparam int CW_LSEL_LSB  = 2;
  localparam int CW_RSELA_LSB = 4;
  localparam int CW_RSELB_LSB = 6;
  localparam int CW_SEL_W     = 2;

  typedef struct packed {
    logic                load;
    logic                push;
    logic [CW_SEL_W-1:0] load_sel;
    logic [CW_SEL_W-1:0] rd_sel_a;
    logic [CW_SEL_W-1:0] rd_sel_b;
  } bank_ctrl_t;

  function automatic bank_ctrl_t decode_ctrl(input logic [7:0] cw);
    bank_ctrl_t c;
    c.load     = cw[CW_LOAD_BIT];
    c.push     = cw[CW_PUSH_BIT];
    c.load_sel = cw[CW_LSEL_LSB  +: CW_SEL_W];
    c.rd_sel_a = cw[CW_RSELA_LSB +: CW_SEL_W];
    c.rd_sel_b = cw[CW_RSELB_LSB +: CW_SEL_W];
    return c;
  endfunction

endpackage

// File: rtl/regbank_out_fifo.sv
// Output queue: circular buffer with valid/ready drain; a push into a full queue
// is accepted only when the head leaves on the same edge, otherwise it stalls.
module out_fifo
  import nic8_pkg::*;
#(
  parameter int WIDTH = NIC8_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     stall,
  output logic                     valid,
  input  logic                     ready,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         last
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               head, tail;
  logic [AW:0]                 cnt_q;
  logic [WIDTH-1:0]            last_q;
  logic                        full, pop, push_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign valid   = (cnt_q != '0);
  assign pop     = valid && ready;
  assign push_ok = push && (!full || pop);
  assign stall   = push && full && !pop;
  assign dout    = mem[head];
  assign count   = cnt_q;
  assign last    = last_q;

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[tail] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (pop) head <= head + 1'b1;
      if (push_ok) begin
        tail   <= tail + 1'b1;
        last_q <= din;
      end
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/regbank.sv
// nic8 register bank: NREGS general registers loaded from dbus, two combinational
// read ports, and an output queue fed from the same bus.
module regbank
  import nic8_pkg::*;
#(
  parameter int WIDTH     = NIC8_WIDTH,
  parameter int NREGS     = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic [$clog2(NREGS)-1:0]     load_sel,
  input  logic [WIDTH-1:0]             dbus,
  input  logic [$clog2(NREGS)-1:0]     rd_sel_a,
  input  logic [$clog2(NREGS)-1:0]     rd_sel_b,
  output logic [WIDTH-1:0]             rd_a,
  output logic [WIDTH-1:0]             rd_b,
  input  logic                         out_push,
  output logic                         out_stall,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(OUT_DEPTH):0]   out_count,
  output logic [WIDTH-1:0]             out_last
);

  logic [NREGS-1:0][WIDTH-1:0] regs;

  always_ff @(posedge clk) begin
    if (reset)     regs <= '0;
    else if (load) regs[load_sel] <= dbus;
  end

  // No write bypass: reads see the pre-edge contents.
  assign rd_a = regs[rd_sel_a];
  assign rd_b = regs[rd_sel_b];

  out_fifo #(.WIDTH(WIDTH), .DEPTH(OUT_DEPTH)) u_out (
    .clk   (clk),
    .reset (reset),
    .push  (out_push),
    .din   (dbus),
    .stall (out_stall),
    .valid (out_valid),
    .ready (out_ready),
    .dout  (out_data),
    .count (out_count),
    .last  (out_last)
  );

endmodule

// File: tb/tb_regbank.sv
// Directed bench for regbank: per-cycle vector table plus hand sequences for
// read-before-write and sustained push/pop streaming.
module tb_regbank;

  logic       clk = 1'b0;
  logic       reset, load, out_push, out_ready;
  logic [1:0] load_sel, rd_sel_a, rd_sel_b;
  logic [7:0] dbus, rd_a, rd_b, out_data, out_last;
  logic       out_stall, out_valid;
  logic [2:0] out_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regbank #(.WIDTH(8), .NREGS(4), .OUT_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .load(load), .load_sel(load_sel), .dbus(dbus),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .rd_a(rd_a), .rd_b(rd_b),
    .out_push(out_push), .out_stall(out_stall), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_last(out_last)
  );

  typedef struct {
    logic       rst, ld;
    logic [1:0] lsel;
    logic [7:0] d;
    logic [1:0] sa, sb;
    logic       push, rdy;
    logic       e_stall;
    logic [7:0] e_a, e_b;
    logic       e_valid;
    logic [7:0] e_data;
    logic [2:0] e_count;
    logic [7:0] e_last;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic rst, logic ld, logic [1:0] lsel, logic [7:0] d,
                              logic [1:0] sa, logic [1:0] sb, logic push, logic rdy,
                              logic e_stall, logic [7:0] e_a, logic [7:0] e_b,
                              logic e_valid, logic [7:0] e_data, logic [2:0] e_count,
                              logic [7:0] e_last);
    vec_t v;
    v.rst = rst; v.ld = ld; v.lsel = lsel; v.d = d; v.sa = sa; v.sb = sb;
    v.push = push; v.rdy = rdy; v.e_stall = e_stall; v.e_a = e_a; v.e_b = e_b;
    v.e_valid = e_valid; v.e_data = e_data; v.e_count = e_count; v.e_last = e_last;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ld, input logic [1:0] lsel,
                       input logic [7:0] d, input logic [1:0] sa, input logic [1:0] sb,
                       input logic push, input logic rdy);
    reset = rst; load = ld; load_sel = lsel; dbus = d;
    rd_sel_a = sa; rd_sel_b = sb; out_push = push; out_ready = rdy;
  endtask

  initial begin
    //            rst ld sel d     sa sb psh rdy | stl a     b     vld data  cnt last
    vecs[0]  = mk(1, 0, 0, 8'h00, 0, 0, 0, 0,   0, 8'h00,8'h00,0, 8'h00, 0, 8'h00);
    vecs[1]  = mk(0, 1, 2, 8'h5A, 2, 0, 0, 0,   0, 8'h5A,8'h00,0, 8'h00, 0, 8'h00);
    vecs[2]  = mk(0, 0, 0, 8'h11, 2, 0, 1, 0,   0, 8'h5A,8'h00,1, 8'h11, 1, 8'h11);
    vecs[3]  = mk(0, 0, 0, 8'h22, 2, 0, 1, 0,   0, 8'h5A,8'h00,1, 8'h11, 2, 8'h22);
    vecs[4]  = mk(0, 0, 0, 8'h33, 2, 0, 1, 0,   0, 8'h5A,8'h00,1, 8'h11, 3, 8'h33);
    vecs[5]  = mk(0, 0, 0, 8'h44, 2, 0, 1, 0,   0, 8'h5A,8'h00,1, 8'h11, 4, 8'h44);
    vecs[6]  = mk(0, 0, 0, 8'h55, 2, 0, 1, 0,   1, 8'h5A,8'h00,1, 8'h11, 4, 8'h44);
    vecs[7]  = mk(0, 0, 0, 8'h55, 2, 0, 1, 1,   0, 8'h5A,8'h00,1, 8'h22, 4, 8'h55);
    vecs[8]  = mk(0, 0, 0, 8'h00, 2, 0, 0, 1,   0, 8'h5A,8'h00,1, 8'h33, 3, 8'h55);
    vecs[9]  = mk(0, 0, 0, 8'h00, 2, 0, 0, 1,   0, 8'h5A,8'h00,1, 8'h44, 2, 8'h55);
    vecs[10] = mk(0, 0, 0, 8'h00, 2, 0, 0, 1,   0, 8'h5A,8'h00,1, 8'h55, 1, 8'h55);
    vecs[11] = mk(0, 0, 0, 8'h00, 2, 0, 0, 1,   0, 8'h5A,8'h00,0, 8'h00, 0, 8'h55);
    vecs[12] = mk(0, 1, 1, 8'hC3, 1, 2, 1, 0,   0, 8'hC3,8'h5A,1, 8'hC3, 1, 8'hC3);
    vecs[13] = mk(0, 0, 0, 8'h66, 1, 2, 1, 1,   0, 8'hC3,8'h5A,1, 8'h66, 1, 8'h66);
    vecs[14] = mk(0, 0, 0, 8'h01, 1, 2, 1, 0,   0, 8'hC3,8'h5A,1, 8'h66, 2, 8'h01);
    vecs[15] = mk(0, 0, 0, 8'h02, 1, 2, 1, 0,   0, 8'hC3,8'h5A,1, 8'h66, 3, 8'h02);
    vecs[16] = mk(1, 0, 0, 8'h03, 1, 2, 1, 0,   0, 8'h00,8'h00,0, 8'h00, 0, 8'h00);
    vecs[17] = mk(0, 0, 0, 8'h7E, 1, 2, 1, 0,   0, 8'h00,8'h00,1, 8'h7E, 1, 8'h7E);
    vecs[18] = mk(0, 0, 0, 8'h00, 1, 2, 0, 1,   0, 8'h00,8'h00,0, 8'h00, 0, 8'h7E);
    vecs[19] = mk(0, 0, 0, 8'h00, 1, 2, 0, 1,   0, 8'h00,8'h00,0, 8'h00, 0, 8'h7E);

    drive(1, 0, 0, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].ld, vecs[i].lsel, vecs[i].d,
            vecs[i].sa, vecs[i].sb, vecs[i].push, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(out_stall), 32'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rd_a", i),  32'(rd_a),      32'(vecs[i].e_a));
      chk($sformatf("v%0d_rd_b", i),  32'(rd_b),      32'(vecs[i].e_b));
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_count", i), 32'(out_count), 32'(vecs[i].e_count));
      chk($sformatf("v%0d_last", i),  32'(out_last),  32'(vecs[i].e_last));
      if (vecs[i].e_valid)
        chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].e_data));
    end

    // Read port shows old contents until the write edge.
    @(negedge clk);
    drive(0, 1, 3, 8'hAB, 3, 3, 0, 0);
    #1;
    chk("nobypass_pre", 32'(rd_a), 32'h00);
    @(posedge clk);
    #1;
    chk("nobypass_post_a", 32'(rd_a), 32'hAB);
    chk("nobypass_post_b", 32'(rd_b), 32'hAB);

    // Sustained push+pop from empty: each value surfaces one edge after its push.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 8'(i), 0, 0, 1, 1);
      #1;
      chk($sformatf("stream%0d_stall", i), 32'(out_stall), 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d_data", i),  32'(out_data),  32'(i));
      chk($sformatf("stream%0d_count", i), 32'(out_count), 32'h1);
    end

    // Drain the last streamed value.
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    chk("stream_drain_count", 32'(out_count), 32'h0);
    chk("stream_last", 32'(out_last), 32'd19);

    // Fill to full with wrapped pointers, then hold: head must stay put.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 8'hA0 + 8'(i), 0, 0, 1, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 0, 0, 0, 0);
    #1;
    chk("wrapfull_count", 32'(out_count), 32'h4);
    chk("wrapfull_head", 32'(out_data), 32'hA0);
    @(posedge clk);
    #1;
    chk("wrapfull_hold", 32'(out_data), 32'hA0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
